// File: rtl/writeback_arbiter.sv
// Two-requester writeback arbiter feeding one register-file write port.
// Optional macro WB_RR_ARB_EN selects round-robin on conflict; otherwise req0 has fixed priority.
module writeback_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [4:0]       req0_reg,
  input  logic [4:0]       req1_reg,
  input  logic [31:0]      req0_value,
  input  logic [31:0]      req1_value,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [4:0]       wb,
  output logic [31:0]      wbValue,
  output logic             regWrite,
  output logic             last_grant,
  output logic [CNT_W-1:0] conflict_count
);

  logic             r_last_grant;
  logic [4:0]       r_wb;
  logic [31:0]      r_wb_value;
  logic             r_reg_write;
  logic [CNT_W-1:0] r_conflict_cnt;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_both;
  logic        w_xfer;
  logic [4:0]  w_win_reg;
  logic [31:0] w_win_value;
  logic        w_conflict;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Grant decision: depends only on valid/hold/rst and the previous winner.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_both = req0_valid & req1_valid;
    if (!rst && !hold) begin
      if (w_both) begin
`ifdef WB_RR_ARB_EN
        w_gnt0 = r_last_grant;
        w_gnt1 = ~r_last_grant;
`else
        w_gnt0 = 1'b1;
`endif
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign w_xfer      = w_gnt0 | w_gnt1;
  assign w_win_reg   = w_gnt1 ? req1_reg   : req0_reg;
  assign w_win_value = w_gnt1 ? req1_value : req0_value;
  assign w_conflict  = w_both & ~hold;

  // Register-file write stage; reg 0 transfers are consumed but never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant   <= 1'b1;
      r_wb           <= '0;
      r_wb_value     <= '0;
      r_reg_write    <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      r_reg_write <= 1'b0;
      if (w_xfer) begin
        r_last_grant <= w_gnt1;
        if (w_win_reg != 5'd0) begin
          r_wb        <= w_win_reg;
          r_wb_value  <= w_win_value;
          r_reg_write <= 1'b1;
        end
      end
      if (w_conflict) r_conflict_cnt <= sat_inc(r_conflict_cnt);
    end
  end

  assign req0_ready     = w_gnt0;
  assign req1_ready     = w_gnt1;
  assign wb             = r_wb;
  assign wbValue        = r_wb_value;
  assign regWrite       = r_reg_write;
  assign last_grant     = r_last_grant;
  assign conflict_count = r_conflict_cnt;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Two instances share all inputs: default counter width and a 2-bit counter for saturation.
module tb_writeback_arbiter;

`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hold, v0, v1;
  logic [4:0]  r0, r1;
  logic [31:0] d0, d1;

  logic        rdy0, rdy1, rw, lg;
  logic [4:0]  wb;
  logic [31:0] wbv;
  logic [15:0] cnt;
  logic        s_rdy0, s_rdy1, s_rw, s_lg;
  logic [4:0]  s_wb;
  logic [31:0] s_wbv;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  logic        m_last;
  logic [4:0]  m_wb;
  logic [31:0] m_val;
  logic        m_rw;
  int          m_cnt, m_cnt_s;

  writeback_arbiter dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(v0), .req1_valid(v1), .req0_reg(r0), .req1_reg(r1),
    .req0_value(d0), .req1_value(d1), .req0_ready(rdy0), .req1_ready(rdy1),
    .wb(wb), .wbValue(wbv), .regWrite(rw), .last_grant(lg), .conflict_count(cnt)
  );

  writeback_arbiter #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(v0), .req1_valid(v1), .req0_reg(r0), .req1_reg(r1),
    .req0_value(d0), .req1_value(d1), .req0_ready(s_rdy0), .req1_ready(s_rdy1),
    .wb(s_wb), .wbValue(s_wbv), .regWrite(s_rw), .last_grant(s_lg), .conflict_count(s_cnt)
  );

  // Expected {ready1, ready0} from the arbitration rules and model state.
  function automatic logic [1:0] exp_ready();
    if (rst || hold) return 2'b00;
    if (v0 && v1) begin
      if (!RR) return 2'b01;
      return m_last ? 2'b01 : 2'b10;
    end
    return {v1, v0};
  endfunction

  task automatic model_edge();
    logic [1:0] g;
    g = exp_ready();
    if (rst) begin
      m_last = 1'b1; m_wb = '0; m_val = '0; m_rw = 1'b0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      m_rw = 1'b0;
      if (g != 2'b00) begin
        m_last = g[1];
        if ((g[1] ? r1 : r0) != 5'd0) begin
          m_wb  = g[1] ? r1 : r0;
          m_val = g[1] ? d1 : d0;
          m_rw  = 1'b1;
        end
      end
      if (v0 && v1 && !hold) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
      end
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic a, input logic b,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic [31:0] da, input logic [31:0] db);
    @(negedge clk);
    rst = r; hold = h; v0 = a; v1 = b; r0 = ra; r1 = rb; d0 = da; d1 = db;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 1, 5'd3, 5'd4, 32'h1, 32'h2);
    checks++;
    if ({rdy1, rdy0, s_rdy1, s_rdy0} !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got=%b want=0000", {rdy1, rdy0, s_rdy1, s_rdy0});
    end
    tick();
    drive(1, 1, 1, 1, 5'd3, 5'd4, 32'h1, 32'h2);
    tick();
    checks++;
    if ({wb, wbv, rw, lg} !== {5'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_regs wb=%0d wbValue=%h regWrite=%b last=%b want 0/0/0/1", wb, wbv, rw, lg);
    end
    checks++;
    if (cnt !== 16'd0 || s_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_count got=%0d/%0d want=0/0", cnt, s_cnt);
    end
  endtask

  task automatic test_single();
    drive(0, 0, 1, 0, 5'd5, 5'd0, 32'h0000_00AA, 32'h0);
    checks++;
    if ({rdy1, rdy0} !== 2'b01) begin
      errors++; $display("FAIL single_ready got=%b want=01", {rdy1, rdy0});
    end
    tick();
    checks++;
    if ({rw, wb, wbv} !== {1'b1, 5'd5, 32'h0000_00AA}) begin
      errors++; $display("FAIL single_write rw=%b wb=%0d val=%h want 1/5/aa", rw, wb, wbv);
    end
    drive(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({rw, wb, wbv} !== {1'b0, 5'd5, 32'h0000_00AA}) begin
      errors++; $display("FAIL single_idle rw=%b wb=%0d val=%h want 0/5/aa", rw, wb, wbv);
    end
  endtask

  task automatic test_conflict();
    logic [1:0] want;
    drive(1, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 5'd3, 5'd4, 32'h300 + i, 32'h400 + i);
      want = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
      checks++;
      if ({rdy1, rdy0} !== want || {s_rdy1, s_rdy0} !== want) begin
        errors++; $display("FAIL conflict_grant cyc=%0d got=%b/%b want=%b", i, {rdy1, rdy0}, {s_rdy1, s_rdy0}, want);
      end
      tick();
      checks++;
      if ({rw, wb} !== {1'b1, want[1] ? 5'd4 : 5'd3}) begin
        errors++; $display("FAIL conflict_wb cyc=%0d rw=%b wb=%0d want=%0d", i, rw, wb, want[1] ? 4 : 3);
      end
      if (i == 3) begin
        checks++;
        if (cnt !== 16'd4 || lg !== (RR ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL conflict_count4 cnt=%0d last=%b want=4/%b", cnt, lg, RR);
        end
      end
    end
    checks++;
    if (cnt !== 16'd5 || s_cnt !== 2'd3) begin
      errors++; $display("FAIL conflict_saturate cnt=%0d small=%0d want=5/3", cnt, s_cnt);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 5'd0, 5'd7, 32'h0, 32'h1234);
      checks++;
      if ({rdy1, rdy0} !== 2'b00) begin
        errors++; $display("FAIL hold_ready cyc=%0d got=%b want=00", i, {rdy1, rdy0});
      end
      tick();
      checks++;
      if (rw !== 1'b0) begin
        errors++; $display("FAIL hold_regwrite cyc=%0d got=%b want=0", i, rw);
      end
    end
    drive(0, 0, 0, 1, 5'd0, 5'd7, 32'h0, 32'h1234);
    checks++;
    if ({rdy1, rdy0} !== 2'b10) begin
      errors++; $display("FAIL hold_release_ready got=%b want=10", {rdy1, rdy0});
    end
    tick();
    checks++;
    if ({rw, wb, wbv, lg} !== {1'b1, 5'd7, 32'h1234, 1'b1}) begin
      errors++; $display("FAIL hold_release_write rw=%b wb=%0d val=%h last=%b", rw, wb, wbv, lg);
    end
  endtask

  task automatic test_reg_zero();
    drive(0, 0, 1, 0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    checks++;
    if ({rdy1, rdy0} !== 2'b01) begin
      errors++; $display("FAIL regzero_ready got=%b want=01", {rdy1, rdy0});
    end
    tick();
    checks++;
    if ({rw, wb, wbv, lg} !== {1'b0, 5'd7, 32'h1234, 1'b0}) begin
      errors++; $display("FAIL regzero_hold rw=%b wb=%0d val=%h last=%b want 0/7/1234/0", rw, wb, wbv, lg);
    end
  endtask

  task automatic test_rst_during_xfer();
    drive(0, 0, 0, 1, 5'd0, 5'd9, 32'h0, 32'h55);
    drive(1, 0, 0, 1, 5'd0, 5'd9, 32'h0, 32'h55);
    checks++;
    if ({rdy1, rdy0} !== 2'b00) begin
      errors++; $display("FAIL rstxfer_ready got=%b want=00", {rdy1, rdy0});
    end
    tick();
    checks++;
    if ({rw, wb, wbv, lg} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
      errors++; $display("FAIL rstxfer_regs rw=%b wb=%0d val=%h last=%b want 0/0/0/1", rw, wb, wbv, lg);
    end
  endtask

  task automatic test_random();
    logic        p0, p1;
    logic [4:0]  pr0, pr1;
    logic [31:0] pd0, pd1;
    logic [1:0]  g;
    p0 = 0; p1 = 0; pr0 = 0; pr1 = 0; pd0 = 0; pd1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; pr0 = 5'($urandom_range(0, 31)); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1; pr1 = 5'($urandom_range(0, 31)); pd1 = $urandom;
      end
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, p0, p1, pr0, pr1, pd0, pd1);
      g = exp_ready();
      checks++;
      if ({rdy1, rdy0} !== g || {s_rdy1, s_rdy0} !== g) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%b/%b want=%b", i, {rdy1, rdy0}, {s_rdy1, s_rdy0}, g);
      end
      tick();
      if (g[0]) p0 = 0;
      if (g[1]) p1 = 0;
      checks++;
      if ({wb, wbv, rw, lg} !== {m_wb, m_val, m_rw, m_last} ||
          {s_wb, s_wbv, s_rw, s_lg} !== {m_wb, m_val, m_rw, m_last}) begin
        errors++; $display("FAIL rand_regs cyc=%0d wb=%0d val=%h rw=%b last=%b want %0d/%h/%b/%b",
                           i, wb, wbv, rw, lg, m_wb, m_val, m_rw, m_last);
      end
      checks++;
      if (cnt !== 16'(m_cnt) || s_cnt !== 2'(m_cnt_s)) begin
        errors++; $display("FAIL rand_count cyc=%0d got=%0d/%0d want=%0d/%0d", i, cnt, s_cnt, m_cnt, m_cnt_s);
      end
    end
  endtask

  initial begin
    rst = 1; hold = 0; v0 = 0; v1 = 0; r0 = 0; r1 = 0; d0 = 0; d1 = 0;
    m_last = 1; m_wb = 0; m_val = 0; m_rw = 0; m_cnt = 0; m_cnt_s = 0;
    test_reset();
    test_single();
    test_conflict();
    test_hold();
    test_reg_zero();
    test_rst_during_xfer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
